// File: rtl/memory_bank_pkg.sv
// Shared definitions for the bl/wl memory-bank programming writer.
//   state_e    : programming sequencer states
//   CNT_W      : width of the per-state cycle counter
//   wl_onehot  : one-hot word-line decode, evaluated one line at a time so the
//                caller can size the result to its own word-line count
package memory_bank_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_e;

    localparam int CNT_W = 4;

    // Returns 1 when word line 'line' is the one selected by row 'row'.
    function automatic logic wl_onehot(input int row, input int line);
        return (row == line);
    endfunction

endpackage

// File: rtl/memory_bank_bl_wl_writer.sv
// Drives the bl/wl programming lines of one tile column. One BL_WIDTH-bit row
// word is accepted per word line over a valid/ready stream and rows
// 0..WL_WIDTH-1 are written in order: bit lines are set up, one word line is
// pulsed, the lines are held, then the next row is loaded.
//
// Ports
//   prog_clk  in   programming clock, rising edge
//   pReset    in   synchronous active-high reset
//   start     in   begin a programming pass (sampled in IDLE only)
//   abort     in   synchronous abort of a pass in progress
//   s_valid   in   s_data holds the next row word
//   s_ready   out  a row word is accepted this cycle
//   s_data    in   row word, s_data[i] drives bl[i]
//   bl        out  bit lines to the tiles
//   wl        out  word lines to the tiles, never multi-hot
//   busy      out  pass in progress
//   done      out  one-cycle pulse on normal completion of a pass
module memory_bank_bl_wl_writer
    import memory_bank_pkg::*;
#(
    parameter int BL_WIDTH        = 3,
    parameter int WL_WIDTH        = 3,
    parameter int SETUP_CYCLES    = 1,
    parameter int WL_PULSE_CYCLES = 2
) (
    input  logic                prog_clk,
    input  logic                pReset,
    input  logic                start,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [BL_WIDTH-1:0] s_data,
    output logic [0:BL_WIDTH-1] bl,
    output logic [0:WL_WIDTH-1] wl,
    output logic                busy,
    output logic                done
);

    localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
    localparam logic [RW-1:0]    LAST_ROW   = RW'(WL_WIDTH - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(WL_PULSE_CYCLES - 1);

    state_e              state_q;
    logic [RW-1:0]       row_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [0:BL_WIDTH-1] bl_q;
    logic [0:WL_WIDTH-1] wl_q;
    logic                s_ready_q;
    logic                busy_q;
    logic                done_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            bl_q      <= '0;
            wl_q      <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (abort && (state_q != IDLE)) begin
            // Abort wins over a same-cycle accept: the offered word is not consumed.
            state_q   <= IDLE;
            row_q     <= '0;
            cnt_q     <= '0;
            bl_q      <= '0;
            wl_q      <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= LOAD;
                        row_q     <= '0;
                        s_ready_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready_q) begin
                        // bl is declared ascending, so map bit by bit rather than
                        // by vector position.
                        for (int i = 0; i < BL_WIDTH; i++) begin
                            bl_q[i] <= s_data[i];
                        end
                        s_ready_q <= 1'b0;
                        cnt_q     <= SETUP_LOAD;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        for (int i = 0; i < WL_WIDTH; i++) begin
                            wl_q[i] <= wl_onehot(int'(row_q), i);
                        end
                        cnt_q   <= PULSE_LOAD;
                        state_q <= PULSE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        wl_q    <= '0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    // wl dropped on entry to HOLD, so bl may change from here on.
                    if (row_q == LAST_ROW) begin
                        done_q  <= 1'b1;
                        bl_q    <= '0;
                        state_q <= DONE;
                    end else begin
                        row_q     <= row_q + RW'(1);
                        s_ready_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    row_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    row_q     <= '0;
                    wl_q      <= '0;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign bl      = bl_q;
    assign wl      = wl_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
